mvau_act_streamer: RTL and testbench

Activation stream transmitter for the MVAU input port. It accepts one SIMD-wide activation word per cycle on a simple write port and buffers each input column (NF words) in a two-bank ping-pong store. It then drives completed columns, in order, as an AXI-stream master into `s0_axis` of `mvau_top`. It replaces the bench-side counter/stimulus logic with synthesizable RTL and sits between the convolution input generator and the MVAU.

---
 rtl/mvau_act_streamer_pkg.sv | 25 ++
 rtl/mvau_act_streamer_if.sv | 22 ++
 rtl/mvau_act_streamer_bank.sv | 31 +++
 rtl/mvau_act_streamer.sv | 141 ++++++++++++++
 tb/tb_mvau_act_streamer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvau_act_streamer_pkg.sv
// mvau_defn: shared constants and types for the MVAU activation path.
//   SIMD, TSrcI, MMV : existing MVAU configuration
//   NF, COLS         : default words per column / columns per image
//   NF_W, COL_W, IMG_W : counter widths (at least 1 bit each)
//   act_word_t       : one stream word, element 0 in the MSB slice
package mvau_defn;

  localparam int unsigned SIMD  = 2;
  localparam int unsigned TSrcI = 4;
  localparam int unsigned NF    = 3;
  localparam int unsigned COLS  = 2;
  localparam int unsigned MMV   = 1;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NF_W  = clog2_min1(NF);
  localparam int unsigned COL_W = clog2_min1(COLS);
  localparam int unsigned IMG_W = clog2_min1(MMV);

  typedef logic [0:SIMD-1][TSrcI-1:0] act_word_t;

endpackage

// File: rtl/mvau_act_streamer_if.sv
// AXI-stream link between the activation streamer and the MVAU input port.
//   tvalid, tdata, tlast : driven by the master
//   tready               : driven by the slave
// tlast exists only when MVAU_STREAMER_TLAST_EN is defined.
interface mvau_act_streamer_if #(
  parameter int unsigned DataW = 8
) ();

  logic             tvalid;
  logic             tready;
  logic [DataW-1:0] tdata;
`ifdef MVAU_STREAMER_TLAST_EN
  logic             tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
`else
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
`endif

endinterface

// File: rtl/mvau_act_streamer_bank.sv
// mvau_streamer_bank: two banks of NF words for the ping-pong column store.
//   clk                 : write clock
//   we, wbank, waddr, wdata : synchronous write port
//   rbank, raddr, rdata     : combinational read port
// Contents are not reset; the full flags in the parent qualify them.
module mvau_streamer_bank #(
  parameter int unsigned DataW = 8,
  parameter int unsigned NF    = 3,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic             rbank,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [2][NF];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/mvau_act_streamer.sv
// mvau_act_streamer: buffers activation columns (NF words) in a two-bank
// ping-pong store and streams completed columns, in order, to the MVAU.
//   aclk, areset       : clock, asynchronous active-high reset
//   s_wr_en, s_wr_data : one activation word per cycle
//   s_wr_full          : current write bank still holds an unsent column
//   m0_axis            : AXI-stream master (tvalid/tready/tdata[/tlast])
//   frame_done         : one-cycle pulse after the last word of a frame
// Optional: MVAU_STREAMER_TLAST_EN adds m0_axis.tlast, high on the last word
// of every column.
module mvau_act_streamer #(
  parameter int unsigned SIMD  = mvau_defn::SIMD,
  parameter int unsigned TSrcI = mvau_defn::TSrcI,
  parameter int unsigned NF    = mvau_defn::NF,
  parameter int unsigned COLS  = mvau_defn::COLS,
  parameter int unsigned MMV   = mvau_defn::MMV
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_wr_en,
  input  logic [SIMD*TSrcI-1:0]   s_wr_data,
  output logic                    s_wr_full,
  mvau_act_streamer_if.master     m0_axis,
  output logic                    frame_done
);

  import mvau_defn::*;

  localparam int unsigned DataW = SIMD * TSrcI;
  localparam int unsigned AddrW = clog2_min1(NF);
  localparam int unsigned ColW  = clog2_min1(COLS);
  localparam int unsigned ImgW  = clog2_min1(MMV);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(NF - 1);
  localparam logic [ColW-1:0]  LastCol  = ColW'(COLS - 1);
  localparam logic [ImgW-1:0]  LastImg  = ImgW'(MMV - 1);

  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [AddrW-1:0] waddr_q, waddr_d;
  logic [AddrW-1:0] raddr_q, raddr_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [ImgW-1:0]  img_q, img_d;
  logic             frame_done_q, frame_done_d;

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = s_wr_en && !full_q[wbank_q];
  assign rd_acc = full_q[rbank_q] && m0_axis.tready;

  // Fill and release may hit the same cycle; the pointers keep them on
  // different banks, so the two flag updates never collide.
  always_comb begin
    full_d       = full_q;
    wbank_d      = wbank_q;
    rbank_d      = rbank_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    col_d        = col_q;
    img_d        = img_q;
    frame_done_d = 1'b0;

    if (wr_acc) begin
      if (waddr_q == LastAddr) begin
        full_d[wbank_q] = 1'b1;
        waddr_d         = '0;
        wbank_d         = ~wbank_q;
      end else begin
        waddr_d = waddr_q + 1'b1;
      end
    end

    if (rd_acc) begin
      if (raddr_q == LastAddr) begin
        full_d[rbank_q] = 1'b0;
        raddr_d         = '0;
        rbank_d         = ~rbank_q;
        if (col_q == LastCol) begin
          col_d = '0;
          if (img_q == LastImg) begin
            img_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            img_d = img_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        raddr_d = raddr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      col_q        <= '0;
      img_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      col_q        <= col_d;
      img_q        <= img_d;
      frame_done_q <= frame_done_d;
    end
  end

  mvau_streamer_bank #(
    .DataW (DataW),
    .NF    (NF),
    .AddrW (AddrW)
  ) u_bank (
    .clk   (aclk),
    .we    (wr_acc),
    .wbank (wbank_q),
    .waddr (waddr_q),
    .wdata (s_wr_data),
    .rbank (rbank_q),
    .raddr (raddr_q),
    .rdata (m0_axis.tdata)
  );

  assign s_wr_full      = full_q[wbank_q];
  assign m0_axis.tvalid = full_q[rbank_q];
  assign frame_done     = frame_done_q;

`ifdef MVAU_STREAMER_TLAST_EN
  assign m0_axis.tlast = full_q[rbank_q] && (raddr_q == LastAddr);
`endif

endmodule

// File: tb/tb_mvau_act_streamer.sv
// Directed testbench for mvau_act_streamer at default parameters
// (NF=3, COLS=2, MMV=1, SIMD=2, TSrcI=4).
module tb_mvau_act_streamer;

  import mvau_defn::*;

  logic      aclk = 1'b0;
  logic      areset = 1'b1;
  logic      s_wr_en = 1'b0;
  act_word_t s_wr_data = '0;
  logic      s_wr_full;
  logic      frame_done;

  int checks = 0;
  int errors = 0;

  mvau_act_streamer_if #(.DataW(8)) m0_axis ();

  mvau_act_streamer dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_wr_en    (s_wr_en),
    .s_wr_data  (s_wr_data),
    .s_wr_full  (s_wr_full),
    .m0_axis    (m0_axis),
    .frame_done (frame_done)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset         = 1'b1;
    s_wr_en        = 1'b0;
    m0_axis.tready = 1'b0;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] w);
    s_wr_en   = 1'b1;
    s_wr_data = w;
    step();
    s_wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    areset         = 1'b1;
    m0_axis.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (m0_axis.tvalid !== 1'b0 || s_wr_full !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got tvalid=%b full=%b done=%b, expected 0 0 0",
                 m0_axis.tvalid, s_wr_full, frame_done);
      end
    end
    areset = 1'b0;
    step();
    checks++;
    if (m0_axis.tvalid !== 1'b0 || s_wr_full !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_outputs: got tvalid=%b full=%b done=%b, expected 0 0 0",
               m0_axis.tvalid, s_wr_full, frame_done);
    end
`ifdef MVAU_STREAMER_TLAST_EN
    checks++;
    if (m0_axis.tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_tlast: got %b, expected 0", m0_axis.tlast);
    end
`endif
  endtask

  task automatic test_column();
    logic [7:0] exp_w [3];
    exp_w = '{8'h12, 8'h34, 8'h56};
    do_reset();
    m0_axis.tready = 1'b1;
    write_word(8'h12);
    write_word(8'h34);
    checks++;
    if (m0_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL col_early_valid: got tvalid=%b, expected 0", m0_axis.tvalid);
    end
    write_word(8'h56);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== exp_w[i]) begin
        errors++;
        $display("FAIL col_word%0d: got valid=%b data=%h, expected 1 %h",
                 i, m0_axis.tvalid, m0_axis.tdata, exp_w[i]);
      end
`ifdef MVAU_STREAMER_TLAST_EN
      checks++;
      if (m0_axis.tlast !== (i == 2)) begin
        errors++;
        $display("FAIL col_tlast%0d: got %b, expected %b", i, m0_axis.tlast, (i == 2));
      end
`endif
      step();
    end
    checks++;
    if (m0_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL col_drain: got tvalid=%b, expected 0", m0_axis.tvalid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m0_axis.tready = 1'b1;
    write_word(8'h12);
    write_word(8'h34);
    write_word(8'h56);
    step();
    m0_axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== 8'h34) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h, expected 1 34",
                 i, m0_axis.tvalid, m0_axis.tdata);
      end
      step();
    end
    m0_axis.tready = 1'b1;
    checks++;
    if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== 8'h34) begin
      errors++;
      $display("FAIL bp_resume: got valid=%b data=%h, expected 1 34",
               m0_axis.tvalid, m0_axis.tdata);
    end
    step();
    checks++;
    if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== 8'h56) begin
      errors++;
      $display("FAIL bp_next: got valid=%b data=%h, expected 1 56",
               m0_axis.tvalid, m0_axis.tdata);
    end
    step();
    checks++;
    if (m0_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got tvalid=%b, expected 0", m0_axis.tvalid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      write_word(8'(i));
      if (i == 3 || i == 5) begin
        checks++;
        if (s_wr_full !== 1'b0) begin
          errors++;
          $display("FAIL full_early%0d: got %b, expected 0", i, s_wr_full);
        end
      end
    end
    checks++;
    if (s_wr_full !== 1'b1) begin
      errors++;
      $display("FAIL full_set: got %b, expected 1", s_wr_full);
    end
    write_word(8'hFF);
    checks++;
    if (s_wr_full !== 1'b1 || m0_axis.tdata !== 8'h01) begin
      errors++;
      $display("FAIL full_drop: got full=%b data=%h, expected 1 01", s_wr_full, m0_axis.tdata);
    end
    m0_axis.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== 8'(i + 1) || s_wr_full !== (i < 3)) begin
        errors++;
        $display("FAIL full_stream%0d: got valid=%b data=%h full=%b, expected 1 %h %b",
                 i, m0_axis.tvalid, m0_axis.tdata, s_wr_full, 8'(i + 1), (i < 3));
      end
      step();
    end
    checks++;
    if (m0_axis.tvalid !== 1'b0 || s_wr_full !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got valid=%b full=%b, expected 0 0", m0_axis.tvalid, s_wr_full);
    end
  endtask

  // Four columns written back-to-back with tready held high: two frames,
  // no bubbles, frame_done exactly after the 6th and 12th handshakes.
  task automatic test_back_to_back();
    logic [7:0] words [12];
    int   widx;
    int   hs;
    int   pulses;
    logic wr_take;
    logic hs_take;
    for (int i = 0; i < 12; i++) words[i] = 8'(8'hA0 + i * 5);
    widx   = 0;
    hs     = 0;
    pulses = 0;
    do_reset();
    m0_axis.tready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s_wr_en = (widx < 12);
      if (widx < 12) s_wr_data = words[widx];
      wr_take = s_wr_en && !s_wr_full;
      hs_take = m0_axis.tvalid;
      if (hs_take) begin
        checks++;
        if (hs >= 12 || m0_axis.tdata !== words[hs % 12]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h, expected %h", hs, m0_axis.tdata, words[hs % 12]);
        end
      end
      step();
      if (wr_take) widx++;
      if (hs_take) hs++;
      checks++;
      if (frame_done !== (hs_take && (hs % 6 == 0))) begin
        errors++;
        $display("FAIL b2b_done_c%0d: got %b, expected %b", c, frame_done,
                 (hs_take && (hs % 6 == 0)));
      end
      if (frame_done === 1'b1) pulses++;
    end
    s_wr_en = 1'b0;
    checks++;
    if (hs != 12 || widx != 12) begin
      errors++;
      $display("FAIL b2b_count: got handshakes=%0d writes=%0d, expected 12 12", hs, widx);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, expected 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_w [3];
    exp_w = '{8'h9A, 8'hBC, 8'hDE};
    do_reset();
    for (int i = 1; i <= 6; i++) write_word(8'(i));
    m0_axis.tready = 1'b1;
    step();
    checks++;
    if (s_wr_full !== 1'b1 || m0_axis.tdata !== 8'h02) begin
      errors++;
      $display("FAIL mid_pre: got full=%b data=%h, expected 1 02", s_wr_full, m0_axis.tdata);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (m0_axis.tvalid !== 1'b0 || s_wr_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got valid=%b full=%b, expected 0 0", m0_axis.tvalid, s_wr_full);
    end
    step();
    checks++;
    if (m0_axis.tvalid !== 1'b0 || s_wr_full !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_held: got valid=%b full=%b done=%b, expected 0 0 0",
               m0_axis.tvalid, s_wr_full, frame_done);
    end
    areset = 1'b0;
    for (int i = 0; i < 3; i++) write_word(exp_w[i]);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m0_axis.tvalid !== 1'b1 || m0_axis.tdata !== exp_w[i]) begin
        errors++;
        $display("FAIL mid_word%0d: got valid=%b data=%h, expected 1 %h",
                 i, m0_axis.tvalid, m0_axis.tdata, exp_w[i]);
      end
      step();
    end
    checks++;
    if (m0_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain: got tvalid=%b, expected 0", m0_axis.tvalid);
    end
  endtask

  initial begin
    m0_axis.tready = 1'b0;
    test_reset();
    test_column();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
